// File: rtl/micro_simd_pkg.sv
// Shared constants for the micro-SIMD lane ALU: opcodes, FSM encodings and
// NZCV bit positions inside each lane's flag nibble.
package micro_simd_pkg;

  localparam logic [2:0] OP_SADD = 3'b000;
  localparam logic [2:0] OP_SSUB = 3'b001;
  localparam logic [2:0] OP_SMUL = 3'b010;
  localparam logic [2:0] OP_SSFT = 3'b011;
  localparam logic [2:0] OP_SSFR = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/micro_simd_lane.sv
// One SIMD lane: combinational add/sub/shift/pass with NZCV generation and a
// single shift-add multiply step. The SMUL result is taken from the step output.
module micro_simd_lane
  import micro_simd_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int STEP_W = $clog2(LANE_W)
) (
  input  logic [LANE_W-1:0]   a,
  input  logic [LANE_W-1:0]   b,
  input  logic [2:0]          op,
  input  logic                sat,
  input  logic [STEP_W-1:0]   step,
  input  logic [2*LANE_W-1:0] acc,
  output logic [2*LANE_W-1:0] acc_next,
  output logic [LANE_W-1:0]   res,
  output logic [3:0]          flags
);

  localparam int M = LANE_W - 1;

  logic [LANE_W:0]     sum, diff;
  logic [2*LANE_W-1:0] shl, shr;
  logic                big, c, v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // Widened shifts keep the bits pushed out of the lane for the carry flag.
  assign shl  = {{LANE_W{1'b0}}, a} << b;
  assign shr  = {a, {LANE_W{1'b0}}} >> b;
  assign big  = {1'b0, b} >= (LANE_W+1)'(LANE_W);

  assign acc_next = acc + (b[step] ? ({{LANE_W{1'b0}}, a} << step) : '0);

  always_comb begin
    res = b;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_SADD: begin
        res = sum[M:0];
        c   = sum[LANE_W];
        v   = (a[M] == b[M]) && (sum[M] != a[M]);
        if (sat && c) res = '1;
      end
      OP_SSUB: begin
        res = diff[M:0];
        c   = ~diff[LANE_W];
        v   = (a[M] != b[M]) && (diff[M] != a[M]);
        if (sat && !c) res = '0;
      end
      OP_SMUL: begin
        res = acc_next[M:0];
        c   = |acc_next[2*LANE_W-1:LANE_W];
        if (sat && c) res = '1;
      end
      OP_SSFT: begin
        res = big ? '0 : shl[M:0];
        c   = big ? |a : |shl[2*LANE_W-1:LANE_W];
      end
      OP_SSFR: begin
        res = big ? '0 : shr[2*LANE_W-1:LANE_W];
        c   = big ? |a : |shr[M:0];
      end
      default: ;
    endcase
    flags         = '0;
    flags[FLAG_N] = res[M];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/micro_simd_lane_alu.sv
// Registered micro-SIMD ALU: LANES independent lanes behind a valid/ready
// handshake, with an iterative LANE_W-step multiply.
module micro_simd_lane_alu
  import micro_simd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic                         i_CLK,
  input  logic                         i_RST,
  input  logic                         i_VALID,
  output logic                         o_READY,
  input  logic [DATA_W-1:0]            i_SRC1,
  input  logic [DATA_W-1:0]            i_SRC2,
  input  logic [2:0]                   i_CTRL,
  input  logic                         i_SAT,
  output logic                         o_VALID,
  input  logic                         i_READY,
  output logic [DATA_W-1:0]            o_RES,
  output logic [4*(DATA_W/LANE_W)-1:0] o_FLAGS
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int STEP_W = $clog2(LANE_W);

  logic [1:0]                     state;
  logic [STEP_W-1:0]              cnt;
  logic [DATA_W-1:0]              a_q, b_q, a_sel, b_sel;
  logic                           sat_q, sat_sel, in_mul, accept;
  logic [2:0]                     op_sel;
  logic [LANES-1:0][LANE_W-1:0]   res_l, res_q;
  logic [LANES-1:0][3:0]          flg_l, flags_q;
  logic [LANES-1:0][2*LANE_W-1:0] acc, acc_nxt;

  assign in_mul  = (state == S_MUL);
  assign o_VALID = (state == S_DONE);
  assign o_READY = (state == S_IDLE) || ((state == S_DONE) && i_READY);
  assign accept  = i_VALID && o_READY;

  // Lanes see live inputs when accepting, captured operands while multiplying.
  assign a_sel   = in_mul ? a_q : i_SRC1;
  assign b_sel   = in_mul ? b_q : i_SRC2;
  assign op_sel  = in_mul ? OP_SMUL : i_CTRL;
  assign sat_sel = in_mul ? sat_q : i_SAT;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    micro_simd_lane #(.LANE_W(LANE_W), .STEP_W(STEP_W)) u_lane (
      .a        (a_sel[k*LANE_W +: LANE_W]),
      .b        (b_sel[k*LANE_W +: LANE_W]),
      .op       (op_sel),
      .sat      (sat_sel),
      .step     (cnt),
      .acc      (acc[k]),
      .acc_next (acc_nxt[k]),
      .res      (res_l[k]),
      .flags    (flg_l[k])
    );
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        S_MUL: begin
          acc <= acc_nxt;
          // Final step's sum is loaded directly, giving LANE_W+1 total latency.
          if (cnt == STEP_W'(LANE_W - 1)) begin
            res_q   <= res_l;
            flags_q <= flg_l;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            a_q   <= i_SRC1;
            b_q   <= i_SRC2;
            sat_q <= i_SAT;
            if (i_CTRL == OP_SMUL) begin
              state <= S_MUL;
              cnt   <= '0;
              acc   <= '0;
            end else begin
              res_q   <= res_l;
              flags_q <= flg_l;
              state   <= S_DONE;
            end
          end else if (state == S_DONE && i_READY) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_RES   = res_q;
  assign o_FLAGS = flags_q;

endmodule

// File: tb/tb_micro_simd_lane_alu.sv
// Scoreboard bench: an 8-bit-lane and a 4-bit-lane instance driven with directed
// and random requests; expected lane results come from an arithmetic model.
module tb_micro_simd_lane_alu;

  typedef struct {
    logic [31:0] res;
    logic [31:0] flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst[2], in_valid[2], out_ready[2], out_valid[2], in_ready[2], sat[2];
  logic [31:0] src1[2], src2[2], res[2];
  logic [2:0]  ctrl[2];
  logic [15:0] flags8;
  logic [31:0] flags4;
  int          mode[2];  // consumer ready: 0 random, 1 held low, 2 held high
  exp_t        q0[$], q1[$];
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  micro_simd_lane_alu #(.DATA_W(32), .LANE_W(8)) u_dut8 (
    .i_CLK(clk), .i_RST(rst[0]), .i_VALID(in_valid[0]), .o_READY(out_ready[0]),
    .i_SRC1(src1[0]), .i_SRC2(src2[0]), .i_CTRL(ctrl[0]), .i_SAT(sat[0]),
    .o_VALID(out_valid[0]), .i_READY(in_ready[0]), .o_RES(res[0]), .o_FLAGS(flags8)
  );

  micro_simd_lane_alu #(.DATA_W(32), .LANE_W(4)) u_dut4 (
    .i_CLK(clk), .i_RST(rst[1]), .i_VALID(in_valid[1]), .o_READY(out_ready[1]),
    .i_SRC1(src1[1]), .i_SRC2(src2[1]), .i_CTRL(ctrl[1]), .i_SAT(sat[1]),
    .o_VALID(out_valid[1]), .i_READY(in_ready[1]), .o_RES(res[1]), .o_FLAGS(flags4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_flags(input int d);
    return (d == 0) ? {16'h0, flags8} : flags4;
  endfunction

  // Lane behaviour from plain integer arithmetic on unsigned/signed lane values.
  function automatic void model(input int lw, input logic [2:0] op, input logic s,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] f);
    longint unsigned mask, x, y, rv, p;
    longint sx, sy, half;
    bit c, v;
    logic [3:0] nib;
    mask = (64'd1 << lw) - 64'd1;
    half = longint'(64'd1 << (lw - 1));
    r = '0;
    f = '0;
    for (int k = 0; k < 32 / lw; k++) begin
      x  = (longint'(a) >> (k * lw)) & mask;
      y  = (longint'(b) >> (k * lw)) & mask;
      sx = (x >= half) ? longint'(x) - 2 * half : longint'(x);
      sy = (y >= half) ? longint'(y) - 2 * half : longint'(y);
      c  = 1'b0;
      v  = 1'b0;
      case (op)
        3'd0: begin
          p = x + y; rv = p & mask; c = (p > mask);
          v = ((sx + sy) >= half) || ((sx + sy) < -half);
          if (s && c) rv = mask;
        end
        3'd1: begin
          c = (x >= y); rv = (x - y) & mask;
          v = ((sx - sy) >= half) || ((sx - sy) < -half);
          if (s && !c) rv = 0;
        end
        3'd2: begin
          p = x * y; rv = p & mask; c = (p > mask);
          if (s && c) rv = mask;
        end
        3'd3: begin
          if (y >= longint'(lw)) begin rv = 0; c = (x != 0); end
          else begin p = x << y; rv = p & mask; c = ((p >> lw) != 0); end
        end
        3'd4: begin
          if (y >= longint'(lw)) begin rv = 0; c = (x != 0); end
          else begin rv = x >> y; c = ((x & ((64'd1 << y) - 64'd1)) != 0); end
        end
        default: rv = y;
      endcase
      nib = {rv[lw-1], rv == 0, c, v};
      r |= 32'(rv << (k * lw));
      f |= 32'(nib) << (4 * k);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      in_ready[d] = (mode[d] == 1) ? 1'b0 : (mode[d] == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  task automatic mon(input int d);
    exp_t        e;
    logic [31:0] pr, pf;
    bit          stalled = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst[d]) begin stalled = 0; continue; end
      if (out_valid[d]) begin
        if (stalled) begin
          chk($sformatf("stable_res%0d", d), res[d], pr);
          chk($sformatf("stable_flags%0d", d), cur_flags(d), pf);
        end
        if (in_ready[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("unexpected_result%0d", d), 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("res%0d", d), res[d], e.res);
            chk($sformatf("flags%0d", d), cur_flags(d), e.flags);
          end
          stalled = 0;
        end else begin
          stalled = 1;
          pr = res[d];
          pf = cur_flags(d);
        end
      end else begin
        stalled = 0;
      end
    end
  endtask

  initial fork
    mon(0);
    mon(1);
  join_none

  task automatic issue(input int d, input logic [2:0] op, input logic s,
                       input logic [31:0] a, input logic [31:0] b, output int tries);
    exp_t e;
    logic ok;
    model((d == 0) ? 8 : 4, op, s, a, b, e.res, e.flags);
    @(negedge clk);
    src1[d] = a; src2[d] = b; ctrl[d] = op; sat[d] = s; in_valid[d] = 1'b1;
    tries = 0;
    forever begin
      #1;
      tries++;
      if (out_ready[d] || tries >= 200) break;
      @(negedge clk);
    end
    ok = out_ready[d];
    chk($sformatf("accept%0d", d), {31'b0, ok}, 32'd1);
    if (ok) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input int lat_exp);
    int t, lat, rdy_hi;
    issue(0, op, s, a, b, t);
    lat = 1;
    rdy_hi = 0;
    while (!out_valid[0] && lat < 64) begin
      if (out_ready[0]) rdy_hi++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({name, "_busy_ready"}, 32'(rdy_hi), 32'd0);
  endtask

  task automatic drain(input int d);
    mode[d] = 2;
    for (int i = 0; i < 50 && out_valid[d]; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_run(input int d, input int n);
    int t;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (d == 0 && (op == 3'd3 || op == 3'd4) && $urandom_range(0, 1) == 1) b &= 32'h0F0F0F0F;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      issue(d, op, 1'($urandom_range(0, 1)), a, b, t);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; src1[d] = '0; src2[d] = '0;
      ctrl[d] = '0; sat[d] = 1'b0; mode[d] = 0; in_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_valid%0d", d), {31'b0, out_valid[d]}, 32'd0);
      chk($sformatf("reset_ready%0d", d), {31'b0, out_ready[d]}, 32'd1);
      chk($sformatf("reset_res%0d", d), res[d], 32'd0);
      chk($sformatf("reset_flags%0d", d), cur_flags(d), 32'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    directed("sadd",     3'd0, 1'b0, 32'h01FF7F10, 32'h01018001, 1);
    directed("sadd_sat", 3'd0, 1'b1, 32'h01FF7F10, 32'h01018001, 1);
    directed("smul",     3'd2, 1'b0, 32'h0310FF02, 32'h05100202, 9);
    directed("smul_sat", 3'd2, 1'b1, 32'h0310FF02, 32'h05100202, 9);
    directed("ssft",     3'd3, 1'b0, 32'h81010F01, 32'h01080403, 1);
    directed("ssfr",     3'd4, 1'b0, 32'h81010F80, 32'h01080403, 1);

    // Result held in DONE while the consumer stalls, then released with a new request.
    drain(0);
    mode[0] = 1;
    directed("bp_sadd", 3'd0, 1'b0, 32'h7F7F0080, 32'h01800080, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", {31'b0, out_valid[0]}, 32'd1);
      chk("bp_ready", {31'b0, out_ready[0]}, 32'd0);
    end
    mode[0] = 2;
    issue(0, 3'd1, 1'b0, 32'h10203040, 32'h20103050, t);
    chk("b2b_accept_tries", 32'(t), 32'd1);
    mode[0] = 0;

    // Reset lands during the fourth multiply cycle and discards the operation.
    issue(0, 3'd2, 1'b0, 32'h12345678, 32'h9ABCDEF0, t);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("mulrst_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("mulrst_ready", {31'b0, out_ready[0]}, 32'd1);
    chk("mulrst_res", res[0], 32'd0);
    chk("mulrst_flags", cur_flags(0), 32'd0);
    void'(q0.pop_back());
    @(negedge clk);
    rst[0] = 1'b0;
    directed("post_rst_sadd", 3'd0, 1'b1, 32'hF0807F01, 32'h20807F01, 1);

    issue(1, 3'd1, 1'b1, 32'h00000035, 32'h00000052, t);
    issue(1, 3'd2, 1'b1, 32'h0000F3A5, 32'h00002F35, t);

    fork
      rand_run(0, 250);
      rand_run(1, 250);
    join

    mode[0] = 2;
    mode[1] = 2;
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
